mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Data-side bus controller between the OpenMIPS core's data port (`ram_ce/we/sel/addr/data`) and a handshaked slave memory (`stb/ack`). It stalls the pipeline while a load/store completes on a slave with arbitrary wait states, then returns load data. It sits directly downstream of the core, in place of the direct core-to-`data_ram` wiring, inside the SOPC top.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUSY cycles before abort (only with `MEM_BUS_TIMEOUT_EN`); legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cpu_ce_i` input 1: core data request (held stable while `stallreq_o`=1).
- `cpu_we_i` input 1: 1 = store, 0 = load.
- `cpu_sel_i` input 4: byte lane enables.
- `cpu_addr_i` input 32: byte address.
- `cpu_data_i` input 32: store data.
- `flush_i` input 1: pipeline flush (exception).
- `cpu_data_o` output 32: load data to the core.
- `stallreq_o` output 1: stall request to the pipeline controller.
- `bus_err_o` output 1: one-cycle pulse on timeout abort.
- `mem_stb_o` output 1: slave strobe.
- `mem_we_o` output 1: slave write enable.
- `mem_sel_o` output 4: slave byte lanes.
- `mem_addr_o` output 32: slave address.
- `mem_data_o` output 32: slave write data.
- `mem_data_i` input 32: slave read data.
- `mem_ack_i` input 1: slave completion; sampled only while `mem_stb_o`=1.

## Operation
- FSM states are IDLE, BUSY, DONE, DRAIN.
- **IDLE**
  - With `cpu_ce_i`=1 and `flush_i`=0: register `we/sel/addr/data` and go to BUSY.
  - `stallreq_o`=1 combinationally in the same cycle.
  - With `flush_i`=1: the request is ignored and `stallreq_o`=0.
- **BUSY**
  - `mem_stb_o`=1 and the registered request drives the `mem_*` outputs, held constant.
  - `stallreq_o`=1.
  - On `mem_ack_i`=1:
    - For a load, latch `mem_data_i` into the read register; stores latch nothing.
    - Go to DONE, or to DRAIN's exit (IDLE) if a flush was recorded.
  - `flush_i`=1 in BUSY sets the `drop` flag. The bus cycle is never abandoned: the controller waits for ack, discards the data, then returns to IDLE without a DONE cycle.
- **DONE**
  - `stallreq_o`=0 and `cpu_data_o` = latched data; the pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally. A back-to-back request is accepted in the following IDLE cycle.
- **DRAIN** (timeout only): see Configuration.
- `cpu_data_o` holds its last latched value outside DONE.
- A store never alters the read register.
- `mem_stb_o` is 0 in every state except BUSY.
- Reset mid-transaction:
  - Async return to IDLE; all outputs go to 0 immediately.
  - The slave must tolerate `stb` dropping without ack.

## Timing
- All outputs reset to 0, the state resets to IDLE, and the `drop` flag and timeout counter clear.
- Minimum access is 3 cycles: cycle 0 IDLE (request seen, stall), cycle 1 BUSY (ack same cycle), cycle 2 DONE (data valid, stall released).
- Latency = 2 + N cycles for ack arriving N≥0 cycles after the first BUSY cycle.
- `stallreq_o` is a Mealy output in IDLE and Moore in the other states.
- All `mem_*` outputs are registered.
- An ack arriving while `mem_stb_o`=0 is ignored.
- `bus_err_o` is registered: high only in the DONE cycle following a timeout abort.
- Simultaneous `flush_i` and `mem_ack_i` in BUSY: the ack completes the transaction, the data is discarded, and the next state is IDLE.

## Configuration
- Macro `MEM_BUS_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter increments each BUSY cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, the controller deasserts `mem_stb_o` and enters DRAIN for one cycle, with `stallreq_o`=1.
  - It then enters DONE with `cpu_data_o`=32'h0000_0000 and `bus_err_o`=1 for that cycle.
  - If `drop` is set, DRAIN goes to IDLE with no error pulse.
  - The counter clears on entry to BUSY.
- **Undefined:**
  - No counter and no DRAIN state; BUSY waits indefinitely.
  - `bus_err_o` is tied to 0.

## Test plan
- Load, zero-wait slave: addr 0x0000_0010, `sel`=4'b1111, slave returns 0xDEAD_BEEF with ack in the first BUSY cycle -> `stallreq_o` high for 2 cycles; `cpu_data_o`=0xDEAD_BEEF in cycle 2 with `stallreq_o`=0.
- Store with 3 wait states: data 0x1234_5678, `sel`=4'b0011 -> `mem_stb_o` held 4 cycles with constant `mem_addr/data/sel`; `mem_we_o`=1; the read register is unchanged; total stall is 5 cycles.
- Back-to-back: load immediately followed by a store -> second request accepted in the IDLE cycle after DONE; `mem_stb_o` low for exactly 2 cycles between the transactions.
- Flush in BUSY: `flush_i` pulsed while waiting, ack 2 cycles later -> no DONE cycle; returns to IDLE; `cpu_data_o` keeps its previous value.
- Timeout (macro defined, `TIMEOUT_CYCLES`=8, slave never acks) -> stb drops after 8 BUSY cycles; one DRAIN cycle; DONE with `bus_err_o`=1 and `cpu_data_o`=0. With the macro undefined -> `stallreq_o` stays high for 100+ cycles and `bus_err_o` stays 0.
- `rst` asserted low mid-BUSY -> `mem_stb_o`, `stallreq_o`, and `cpu_data_o` go to 0 asynchronously; after release, a fresh load completes normally.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Data-side bus controller: stalls the core while a load/store completes on a stb/ack slave.
// Optional busy timeout with abort/error pulse is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic        drop_q, drop_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [7:0] TMO     = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    drop_d  = drop_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          state_d = S_BUSY;
          stb_d   = 1'b1;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          drop_d  = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_BUSY: begin
        if (flush_i) drop_d = 1'b1;
        // A flush never abandons the bus cycle; it only discards the result.
        if (mem_ack_i && stb_q) begin
          stb_d = 1'b0;
          if (drop_q || flush_i) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = S_DONE;
            if (!we_q) rdata_d = mem_data_i;
          end
        end
`ifdef MEM_BUS_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TMO) begin
          stb_d   = 1'b0;
          state_d = S_DRAIN;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
`ifdef MEM_BUS_TIMEOUT_EN
      S_DRAIN: begin
        drop_d = 1'b0;
        if (drop_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      drop_q  <= 1'b0;
      sel_q   <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      drop_q  <= drop_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Stall is Mealy in IDLE (request seen this cycle), Moore elsewhere; forced low in reset.
  assign stallreq_o = rst && ((state_q == S_IDLE) ? (cpu_ce_i && !flush_i)
                                                  : (state_q != S_DONE));
  assign cpu_data_o = rdata_q;
  assign mem_stb_o  = stb_q;
  assign mem_we_o   = we_q;
  assign mem_sel_o  = sel_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
  assign bus_err_o  = err_q;
`else
  assign bus_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: inputs change on the falling edge, outputs checked 1ns later.
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i, flush_i, mem_ack_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_addr_i, cpu_data_i, mem_data_i;
  logic [31:0] cpu_data_o, mem_addr_o, mem_data_o;
  logic        stallreq_o, bus_err_o, mem_stb_o, mem_we_o;
  logic [3:0]  mem_sel_o;
  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .flush_i(flush_i),
    .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
    .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                     input logic [31:0] data);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = addr; cpu_data_i = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_stall, bad_err, bad_stb;
    rst = 1'b0; cpu_ce_i = 0; cpu_we_i = 0; flush_i = 0; mem_ack_i = 0;
    cpu_sel_i = 0; cpu_addr_i = 0; cpu_data_i = 0; mem_data_i = 0;
    repeat (2) next();
    #1;
    chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
    chk("rst_stb",   {31'b0, mem_stb_o},  32'd0);
    chk("rst_data",  cpu_data_o, 32'h0);
    chk("rst_err",   {31'b0, bus_err_o},  32'd0);
    chk("rst_addr",  mem_addr_o, 32'h0);
    rst = 1'b1;

    // Load, zero-wait slave
    next(); req(1'b0, 4'hF, 32'h0000_0010, 32'h0); #1;
    chk("ld_idle_stall", {31'b0, stallreq_o}, 32'd1);
    chk("ld_idle_stb",   {31'b0, mem_stb_o},  32'd0);
    next(); mem_ack_i = 1; mem_data_i = 32'hDEAD_BEEF; #1;
    chk("ld_busy_stb",   {31'b0, mem_stb_o},  32'd1);
    chk("ld_busy_stall", {31'b0, stallreq_o}, 32'd1);
    chk("ld_busy_addr",  mem_addr_o, 32'h10);
    chk("ld_busy_we",    {31'b0, mem_we_o},   32'd0);
    chk("ld_busy_sel",   {28'b0, mem_sel_o},  32'hF);
    next(); mem_ack_i = 0; cpu_ce_i = 0; #1;
    chk("ld_done_stall", {31'b0, stallreq_o}, 32'd0);
    chk("ld_done_data",  cpu_data_o, 32'hDEAD_BEEF);
    chk("ld_done_stb",   {31'b0, mem_stb_o},  32'd0);

    // Stray ack while idle is ignored
    next(); mem_ack_i = 1; mem_data_i = 32'h9999_9999; #1;
    chk("stray_stall", {31'b0, stallreq_o}, 32'd0);
    next(); mem_ack_i = 0; #1;
    chk("stray_stb",  {31'b0, mem_stb_o}, 32'd0);
    chk("stray_data", cpu_data_o, 32'hDEAD_BEEF);

    // Store with 3 wait states
    next(); req(1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678); mem_data_i = 32'h0BAD_0BAD; #1;
    chk("st_idle_stall", {31'b0, stallreq_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      next(); mem_ack_i = (i == 3); #1;
      chk($sformatf("st_b%0d_stb", i),   {31'b0, mem_stb_o},  32'd1);
      chk($sformatf("st_b%0d_stall", i), {31'b0, stallreq_o}, 32'd1);
      chk($sformatf("st_b%0d_addr", i),  mem_addr_o, 32'h20);
      chk($sformatf("st_b%0d_wdat", i),  mem_data_o, 32'h1234_5678);
      chk($sformatf("st_b%0d_sel", i),   {28'b0, mem_sel_o}, 32'h3);
      chk($sformatf("st_b%0d_we", i),    {31'b0, mem_we_o},  32'd1);
    end
    next(); mem_ack_i = 0; cpu_ce_i = 0; #1;
    chk("st_done_stall", {31'b0, stallreq_o}, 32'd0);
    chk("st_done_rdata", cpu_data_o, 32'hDEAD_BEEF);
    chk("st_done_stb",   {31'b0, mem_stb_o},  32'd0);

    // Back-to-back load then store
    next(); req(1'b0, 4'hF, 32'h0000_0030, 32'h0); #1;
    chk("bb_idle1_stall", {31'b0, stallreq_o}, 32'd1);
    next(); mem_ack_i = 1; mem_data_i = 32'hCAFE_F00D; #1;
    chk("bb_busy1_stb", {31'b0, mem_stb_o}, 32'd1);
    next(); mem_ack_i = 0; req(1'b1, 4'hF, 32'h0000_0040, 32'h55AA_55AA); #1;
    chk("bb_done1_stall", {31'b0, stallreq_o}, 32'd0);
    chk("bb_done1_data",  cpu_data_o, 32'hCAFE_F00D);
    chk("bb_done1_stb",   {31'b0, mem_stb_o}, 32'd0);
    next(); #1;
    chk("bb_idle2_stb",   {31'b0, mem_stb_o},  32'd0);
    chk("bb_idle2_stall", {31'b0, stallreq_o}, 32'd1);
    next(); mem_ack_i = 1; #1;
    chk("bb_busy2_stb",  {31'b0, mem_stb_o}, 32'd1);
    chk("bb_busy2_addr", mem_addr_o, 32'h40);
    chk("bb_busy2_we",   {31'b0, mem_we_o},  32'd1);
    next(); mem_ack_i = 0; cpu_ce_i = 0; #1;
    chk("bb_done2_stall", {31'b0, stallreq_o}, 32'd0);
    chk("bb_done2_data",  cpu_data_o, 32'hCAFE_F00D);

    // Flush while waiting, ack two cycles later
    next(); req(1'b0, 4'hF, 32'h0000_0050, 32'h0); mem_data_i = 32'h1111_1111; #1;
    chk("fl_idle_stall", {31'b0, stallreq_o}, 32'd1);
    next(); flush_i = 1; #1;
    chk("fl_busy_stb", {31'b0, mem_stb_o}, 32'd1);
    next(); flush_i = 0; cpu_ce_i = 0; #1;
    chk("fl_wait1_stb",   {31'b0, mem_stb_o},  32'd1);
    chk("fl_wait1_stall", {31'b0, stallreq_o}, 32'd1);
    next(); mem_ack_i = 1; #1;
    chk("fl_wait2_stb", {31'b0, mem_stb_o}, 32'd1);
    next(); mem_ack_i = 0; #1;
    chk("fl_after_stall", {31'b0, stallreq_o}, 32'd0);
    chk("fl_after_stb",   {31'b0, mem_stb_o},  32'd0);
    chk("fl_after_data",  cpu_data_o, 32'hCAFE_F00D);
    next(); #1;
    chk("fl_idle_stb", {31'b0, mem_stb_o}, 32'd0);

    // Flush in IDLE ignores the request
    next(); req(1'b0, 4'hF, 32'h0000_0054, 32'h0); flush_i = 1; #1;
    chk("fli_stall", {31'b0, stallreq_o}, 32'd0);
    next(); cpu_ce_i = 0; flush_i = 0; #1;
    chk("fli_stb", {31'b0, mem_stb_o}, 32'd0);

    // Flush and ack in the same BUSY cycle
    next(); req(1'b0, 4'hF, 32'h0000_0058, 32'h0); #1;
    next(); flush_i = 1; mem_ack_i = 1; mem_data_i = 32'h2222_2222; #1;
    chk("fa_busy_stb", {31'b0, mem_stb_o}, 32'd1);
    next(); flush_i = 0; mem_ack_i = 0; cpu_ce_i = 0; #1;
    chk("fa_stall", {31'b0, stallreq_o}, 32'd0);
    chk("fa_stb",   {31'b0, mem_stb_o},  32'd0);
    chk("fa_data",  cpu_data_o, 32'hCAFE_F00D);

    // Slave that never acks
    next(); req(1'b0, 4'hF, 32'h0000_0070, 32'h0); #1;
    bad_stall = 0; bad_err = 0; bad_stb = 0;
`ifdef MEM_BUS_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      next(); #1;
      if (mem_stb_o !== 1'b1) bad_stb++;
      if (stallreq_o !== 1'b1) bad_stall++;
    end
    chk("to_busy_stb",   bad_stb, 0);
    chk("to_busy_stall", bad_stall, 0);
    next(); #1;
    chk("to_drain_stb",   {31'b0, mem_stb_o},  32'd0);
    chk("to_drain_stall", {31'b0, stallreq_o}, 32'd1);
    chk("to_drain_err",   {31'b0, bus_err_o},  32'd0);
    next(); cpu_ce_i = 0; #1;
    chk("to_done_err",   {31'b0, bus_err_o},  32'd1);
    chk("to_done_data",  cpu_data_o, 32'h0);
    chk("to_done_stall", {31'b0, stallreq_o}, 32'd0);
    next(); #1;
    chk("to_after_err", {31'b0, bus_err_o}, 32'd0);
    next(); req(1'b0, 4'hF, 32'h0000_0074, 32'h0);
    next(); next();
`else
    for (int i = 0; i < 120; i++) begin
      next(); #1;
      if (stallreq_o !== 1'b1) bad_stall++;
      if (bus_err_o !== 1'b0) bad_err++;
      if (mem_stb_o !== 1'b1) bad_stb++;
    end
    chk("hang_stall", bad_stall, 0);
    chk("hang_err",   bad_err, 0);
    chk("hang_stb",   bad_stb, 0);
`endif

    // Asynchronous reset while BUSY
    cpu_ce_i = 0;
    #1;
    chk("pre_rst_stb", {31'b0, mem_stb_o}, 32'd1);
    rst = 1'b0; #1;
    chk("arst_stb",   {31'b0, mem_stb_o},  32'd0);
    chk("arst_stall", {31'b0, stallreq_o}, 32'd0);
    chk("arst_data",  cpu_data_o, 32'h0);
    next(); rst = 1'b1;

    // Fresh load after reset
    next(); req(1'b0, 4'hF, 32'h0000_0080, 32'h0); #1;
    chk("post_idle_stall", {31'b0, stallreq_o}, 32'd1);
    next(); mem_ack_i = 1; mem_data_i = 32'h0BAD_F00D; #1;
    chk("post_busy_addr", mem_addr_o, 32'h80);
    next(); mem_ack_i = 0; cpu_ce_i = 0; #1;
    chk("post_done_stall", {31'b0, stallreq_o}, 32'd0);
    chk("post_done_data",  cpu_data_o, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
